// File: rtl/arm_ctrl_seq.sv
// Fetch/decode/issue sequencer for the RV32I-subset datapath.
// It owns the PC, fetches instructions over a req/valid handshake, decodes
// ADDI/ADD/SUB/BEQ/BNE into datapath controls and resolves branches from EQ.
module arm_ctrl_seq #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_valid,
    input  logic [31:0]           imem_rdata,
    input  logic                  EQ,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] rs1,
    output logic [DATA_WIDTH-1:0] rs2,
    output logic [DATA_WIDTH-1:0] rd,
    output logic [DATA_WIDTH-1:0] ImmOp,
    output logic                  RegWrite,
    output logic                  ALUsrc,
    output logic                  ALUctrl,
    output logic                  illegal,
    output logic [31:0]           instret
);

    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    typedef enum logic [1:0] {StFetch, StDecode, StExec} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]           instr_q, instr_d;
    logic [4:0]            rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [DATA_WIDTH-1:0] imm_q, imm_d;
    logic                  alusrc_q, alusrc_d, aluctrl_q, aluctrl_d;
    logic                  wr_q, wr_d, beq_q, beq_d, bne_q, bne_d, ill_q, ill_d;
    logic [31:0]           instret_q, instret_d;

    logic [6:0]            opcode, funct7;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] dec_imm;
    logic                  dec_src, dec_ctrl, dec_wr, dec_beq, dec_bne, dec_ill;
    logic                  taken;

    assign opcode = instr_q[6:0];
    assign funct3 = instr_q[14:12];
    assign funct7 = instr_q[31:25];

    // Decode the latched instruction into datapath controls.
    always_comb begin
        dec_imm  = '0;
        dec_src  = 1'b0;
        dec_ctrl = 1'b0;
        dec_wr   = 1'b0;
        dec_beq  = 1'b0;
        dec_bne  = 1'b0;
        dec_ill  = 1'b1;
        case (opcode)
            OpImm: begin
                if (funct3 == 3'b000) begin
                    dec_imm = {{(DATA_WIDTH-12){instr_q[31]}}, instr_q[31:20]};
                    dec_src = 1'b1;
                    dec_wr  = (instr_q[11:7] != 5'd0);
                    dec_ill = 1'b0;
                end
            end
            OpReg: begin
                if (funct3 == 3'b000 && (funct7 == 7'b0000000 || funct7 == 7'b0100000)) begin
                    dec_ctrl = funct7[5];
                    dec_wr   = (instr_q[11:7] != 5'd0);
                    dec_ill  = 1'b0;
                end
            end
            OpBranch: begin
                if (funct3 == 3'b000 || funct3 == 3'b001) begin
                    dec_imm  = {{(DATA_WIDTH-13){instr_q[31]}}, instr_q[31], instr_q[7],
                                instr_q[30:25], instr_q[11:8], 1'b0};
                    dec_ctrl = 1'b1;
                    dec_beq  = ~funct3[0];
                    dec_bne  = funct3[0];
                    dec_ill  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign taken = (beq_q & EQ) | (bne_q & ~EQ);

    // Next-state logic: fetch handshake, decode latch, PC/instret commit in EXEC.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        imm_d     = imm_q;
        alusrc_d  = alusrc_q;
        aluctrl_d = aluctrl_q;
        wr_d      = wr_q;
        beq_d     = beq_q;
        bne_d     = bne_q;
        ill_d     = ill_q;
        instret_d = instret_q;
        case (state_q)
            StFetch: begin
                if (imem_valid) begin
                    instr_d = imem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                rs1_d     = instr_q[19:15];
                rs2_d     = instr_q[24:20];
                rd_d      = instr_q[11:7];
                imm_d     = dec_imm;
                alusrc_d  = dec_src;
                aluctrl_d = dec_ctrl;
                wr_d      = dec_wr;
                beq_d     = dec_beq;
                bne_d     = dec_bne;
                ill_d     = dec_ill;
                state_d   = StExec;
            end
            StExec: begin
                pc_d      = taken ? pc_q + imm_q : pc_q + DATA_WIDTH'(4);
                instret_d = instret_q + 32'd1;
                state_d   = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            alusrc_q  <= 1'b0;
            aluctrl_q <= 1'b0;
            wr_q      <= 1'b0;
            beq_q     <= 1'b0;
            bne_q     <= 1'b0;
            ill_q     <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            imm_q     <= imm_d;
            alusrc_q  <= alusrc_d;
            aluctrl_q <= aluctrl_d;
            wr_q      <= wr_d;
            beq_q     <= beq_d;
            bne_q     <= bne_d;
            ill_q     <= ill_d;
            instret_q <= instret_d;
        end
    end

    // The request drops during the reset cycle itself so memory sees it abandoned.
    assign imem_req  = rst && (state_q == StFetch);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign rs1       = {{(DATA_WIDTH-5){1'b0}}, rs1_q};
    assign rs2       = {{(DATA_WIDTH-5){1'b0}}, rs2_q};
    assign rd        = {{(DATA_WIDTH-5){1'b0}}, rd_q};
    assign ImmOp     = imm_q;
    assign ALUsrc    = alusrc_q;
    assign ALUctrl   = aluctrl_q;
    assign RegWrite  = (state_q == StExec) && wr_q;
    assign illegal   = (state_q == StExec) && ill_q;
    assign instret   = instret_q;

endmodule
